// File: rtl/ahb_matrix_pkg.sv
// rtl/ahb_matrix_pkg.sv - shared AHB transfer, response and default-slave state types
package ahb_matrix_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DFLT_IDLE = 2'b00,
    DFLT_ERR1 = 2'b01,
    DFLT_ERR2 = 2'b10
  } dflt_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR
module ahb_default_slave
  import ahb_matrix_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       ready,
  output logic       resp
);

  dflt_state_e state_q, state_d;
  htrans_e     trans;
  logic        active;

  assign trans  = htrans_e'(HTRANS);
  assign active = sel && HREADY && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DFLT_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    case (state_q)
      DFLT_IDLE: if (active) state_d = DFLT_ERR1;
      DFLT_ERR1: begin
        ready   = 1'b0;
        resp    = HRESP_ERROR;
        state_d = DFLT_ERR2;
      end
      DFLT_ERR2: begin
        resp    = HRESP_ERROR;
        state_d = active ? DFLT_ERR1 : DFLT_IDLE;
      end
      default: state_d = DFLT_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_bus_matrix_nslave.sv
// rtl/ahb_bus_matrix_nslave.sv - single-master AHB matrix: decode, data-phase select, response mux
module ahb_bus_matrix_nslave
  import ahb_matrix_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
  parameter int REMAP_SLAVE = 1
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [3:0]                   REMAP,
  input  logic                         HSELM,
  input  logic [1:0]                   HTRANSM,
  input  logic                         HWRITEM,
  input  logic [2:0]                   HSIZEM,
  input  logic [2:0]                   HBURSTM,
  input  logic [3:0]                   HPROTM,
  input  logic [DATA_W-1:0]            HWDATAM,
  input  logic [ADDR_W-1:0]            HADDRM,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATAS,
  input  logic [NUM_SLAVES-1:0]        HRESPS,
  input  logic [NUM_SLAVES-1:0]        HREADYoutS,
  output logic [NUM_SLAVES-1:0]        HSELS,
  output logic [ADDR_W-1:0]            HADDRS,
  output logic [1:0]                   HTRANSS,
  output logic                         HWRITES,
  output logic [2:0]                   HSIZES,
  output logic [2:0]                   HBURSTS,
  output logic [3:0]                   HPROTS,
  output logic [DATA_W-1:0]            HWDATA,
  output logic                         HREADYMUXS,
  output logic [DATA_W-1:0]            HRDATAM,
  output logic                         HRESPM,
  output logic                         HREADYoutM
);

  localparam int DSEL_W = $clog2(NUM_SLAVES + 1);
  localparam logic [DSEL_W-1:0] DFLT_IDX  = DSEL_W'(NUM_SLAVES);
  localparam logic [DSEL_W-1:0] REMAP_IDX = DSEL_W'(REMAP_SLAVE);

  logic [NUM_SLAVES-1:0] hit;
  logic [DSEL_W-1:0]     dec_sel;
  logic [DSEL_W-1:0]     dsel_q, dsel_d;
  logic                  dflt_ready, dflt_resp;
  logic                  unused_remap;

  assign unused_remap = ^REMAP[3:1];

  assign HADDRS  = HADDRM;
  assign HTRANSS = HTRANSM;
  assign HWRITES = HWRITEM;
  assign HSIZES  = HSIZEM;
  assign HBURSTS = HBURSTM;
  assign HPROTS  = HPROTM;
  assign HWDATA  = HWDATAM;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      hit[i] = (HADDRM & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W];
  end

  // Descending scan so the lowest-indexed hit is the last assignment and wins.
  always_comb begin
    dec_sel = DFLT_IDX;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (hit[i]) dec_sel = DSEL_W'(i);
    if (REMAP[0] && dec_sel == '0) dec_sel = REMAP_IDX;
    if (!HSELM) dec_sel = DFLT_IDX;
  end

  always_comb begin
    HSELS = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      HSELS[i] = (dec_sel == DSEL_W'(i));
  end

  assign dsel_d = HREADYoutM ? dec_sel : dsel_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dsel_q <= DFLT_IDX;
    else          dsel_q <= dsel_d;
  end

  ahb_default_slave u_default_slave (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .sel     (dec_sel == DFLT_IDX && HSELM),
    .HTRANS  (HTRANSM),
    .HREADY  (HREADYoutM),
    .ready   (dflt_ready),
    .resp    (dflt_resp)
  );

  always_comb begin
    HREADYoutM = dflt_ready;
    HRESPM     = dflt_resp;
    HRDATAM    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == DSEL_W'(i)) begin
        HREADYoutM = HREADYoutS[i];
        HRESPM     = HRESPS[i];
        HRDATAM    = HRDATAS[i*DATA_W +: DATA_W];
      end
    end
  end

  assign HREADYMUXS = HREADYoutM;

endmodule

// File: tb/tb_ahb_bus_matrix_nslave.sv
// tb/tb_ahb_bus_matrix_nslave.sv - directed self-checking bench for ahb_bus_matrix_nslave
module tb_ahb_bus_matrix_nslave;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam logic [NS*AW-1:0] BASE = {32'h1000_0000, 32'h3000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hE000_0000};
  localparam logic [DW-1:0] S0 = 64'h0000_1111_AAAA_0000;
  localparam logic [DW-1:0] S1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [DW-1:0] S2 = 64'h2222_3333_4444_5555;
  localparam logic [DW-1:0] S3 = 64'h3333_0000_9999_7777;

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic [3:0]     REMAP;
  logic           HSELM;
  logic [1:0]     HTRANSM;
  logic           HWRITEM;
  logic [2:0]     HSIZEM;
  logic [2:0]     HBURSTM;
  logic [3:0]     HPROTM;
  logic [DW-1:0]  HWDATAM;
  logic [AW-1:0]  HADDRM;
  logic [NS*DW-1:0] HRDATAS;
  logic [NS-1:0]  HRESPS;
  logic [NS-1:0]  HREADYoutS;
  logic [NS-1:0]  HSELS;
  logic [AW-1:0]  HADDRS;
  logic [1:0]     HTRANSS;
  logic           HWRITES;
  logic [2:0]     HSIZES;
  logic [2:0]     HBURSTS;
  logic [3:0]     HPROTS;
  logic [DW-1:0]  HWDATA;
  logic           HREADYMUXS;
  logic [DW-1:0]  HRDATAM;
  logic           HRESPM;
  logic           HREADYoutM;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_bus_matrix_nslave #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SLV_BASE   (BASE),
    .SLV_MASK   (MASK),
    .REMAP_SLAVE(1)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .REMAP      (REMAP),
    .HSELM      (HSELM),
    .HTRANSM    (HTRANSM),
    .HWRITEM    (HWRITEM),
    .HSIZEM     (HSIZEM),
    .HBURSTM    (HBURSTM),
    .HPROTM     (HPROTM),
    .HWDATAM    (HWDATAM),
    .HADDRM     (HADDRM),
    .HRDATAS    (HRDATAS),
    .HRESPS     (HRESPS),
    .HREADYoutS (HREADYoutS),
    .HSELS      (HSELS),
    .HADDRS     (HADDRS),
    .HTRANSS    (HTRANSS),
    .HWRITES    (HWRITES),
    .HSIZES     (HSIZES),
    .HBURSTS    (HBURSTS),
    .HPROTS     (HPROTS),
    .HWDATA     (HWDATA),
    .HREADYMUXS (HREADYMUXS),
    .HRDATAM    (HRDATAM),
    .HRESPM     (HRESPM),
    .HREADYoutM (HREADYoutM)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr);
    HSELM   = sel;
    HTRANSM = trans;
    HADDRM  = addr;
  endtask

  initial begin
    HRESETn    = 1'b0;
    REMAP      = 4'h0;
    HWRITEM    = 1'b0;
    HSIZEM     = 3'b011;
    HBURSTM    = 3'b000;
    HPROTM     = 4'b0011;
    HWDATAM    = 64'hCAFE_F00D_5A5A_A5A5;
    HRDATAS    = {S3, S2, S1, S0};
    HRESPS     = '0;
    HREADYoutS = '1;
    drive(1'b0, 2'b00, 32'h0);
    repeat (2) step();

    check("rst_ready", 64'(HREADYoutM), 64'd1);
    check("rst_resp",  64'(HRESPM),     64'd0);
    check("rst_rdata", HRDATAM,         64'd0);

    // Reset asserted in the middle of an error response
    HRESETn = 1'b1;
    drive(1'b1, 2'b10, 32'hF000_0000);
    #1 check("unmap_hsels", 64'(HSELS), 64'd0);
    step();
    check("pre_rst_err1_ready", 64'(HREADYoutM), 64'd0);
    check("pre_rst_err1_resp",  64'(HRESPM),     64'd1);
    drive(1'b1, 2'b00, 32'hF000_0000);
    HRESETn = 1'b0;
    #1;
    check("midrst_ready", 64'(HREADYoutM), 64'd1);
    check("midrst_resp",  64'(HRESPM),     64'd0);
    check("midrst_rdata", HRDATAM,         64'd0);
    drive(1'b1, 2'b10, 32'h2000_0010);
    #1 check("rst_hsels", 64'(HSELS), 64'b0010);
    step();
    HRESETn = 1'b1;
    step();
    check("post_rst_rdata", HRDATAM, S1);
    check("post_rst_resp",  64'(HRESPM), 64'd0);

    // Plain decode and broadcast
    drive(1'b1, 2'b10, 32'h2000_0010);
    #1;
    check("dec_hsels",  64'(HSELS),   64'b0010);
    check("bc_haddr",   64'(HADDRS),  64'h2000_0010);
    check("bc_htrans",  64'(HTRANSS), 64'd2);
    check("bc_hwdata",  HWDATA,       64'hCAFE_F00D_5A5A_A5A5);
    check("bc_hprot",   64'(HPROTS),  64'b0011);
    step();
    check("dec_rdata", HRDATAM, S1);
    check("dec_ready", 64'(HREADYoutM), 64'd1);

    // Three wait states from slave 2
    drive(1'b1, 2'b10, 32'h3000_0000);
    #1 check("s2_hsels", 64'(HSELS), 64'b0100);
    step();
    HREADYoutS = 4'b1011;
    drive(1'b1, 2'b10, 32'h2000_0010);
    #1;
    check("wait0_ready", 64'(HREADYoutM), 64'd0);
    check("wait0_mux",   64'(HREADYMUXS), 64'd0);
    check("wait0_hsels", 64'(HSELS),      64'b0010);
    check("wait0_rdata", HRDATAM,         S2);
    for (int k = 1; k < 3; k++) begin
      step();
      check($sformatf("wait%0d_ready", k), 64'(HREADYoutM), 64'd0);
      check($sformatf("wait%0d_rdata", k), HRDATAM,         S2);
    end
    step();
    HREADYoutS = '1;
    #1;
    check("rel_ready", 64'(HREADYoutM), 64'd1);
    check("rel_rdata", HRDATAM,         S2);
    step();
    check("after_wait_rdata", HRDATAM, S1);

    // Slave error passes through
    drive(1'b1, 2'b10, 32'h3000_0000);
    step();
    HRESPS = 4'b0100;
    #1 check("s2_err_resp", 64'(HRESPM), 64'd1);
    HRESPS = '0;
    #1 check("s2_ok_resp",  64'(HRESPM), 64'd0);

    // Default slave: error, back-to-back error, IDLE OKAY
    drive(1'b1, 2'b10, 32'hF000_0000);
    step();
    check("err1_ready", 64'(HREADYoutM), 64'd0);
    check("err1_resp",  64'(HRESPM),     64'd1);
    check("err1_rdata", HRDATAM,         64'd0);
    step();
    check("err2_ready", 64'(HREADYoutM), 64'd1);
    check("err2_resp",  64'(HRESPM),     64'd1);
    step();
    check("b2b_err1_ready", 64'(HREADYoutM), 64'd0);
    check("b2b_err1_resp",  64'(HRESPM),     64'd1);
    drive(1'b1, 2'b00, 32'hF000_0000);
    step();
    check("b2b_err2_ready", 64'(HREADYoutM), 64'd1);
    check("b2b_err2_resp",  64'(HRESPM),     64'd1);
    step();
    check("idle_okay_ready", 64'(HREADYoutM), 64'd1);
    check("idle_okay_resp",  64'(HRESPM),     64'd0);
    step();
    check("idle_okay2_ready", 64'(HREADYoutM), 64'd1);
    check("idle_okay2_resp",  64'(HRESPM),     64'd0);
    drive(1'b0, 2'b10, 32'h2000_0010);
    #1 check("nosel_hsels", 64'(HSELS), 64'd0);
    step();
    check("nosel_ready", 64'(HREADYoutM), 64'd1);
    check("nosel_resp",  64'(HRESPM),     64'd0);

    // Remap of slave 0's region
    REMAP = 4'b0001;
    drive(1'b1, 2'b10, 32'h0000_0004);
    #1 check("remap_hsels", 64'(HSELS), 64'b0010);
    step();
    check("remap_rdata", HRDATAM, S1);
    REMAP = 4'b0000;
    #1 check("noremap_hsels", 64'(HSELS), 64'b0001);
    step();
    check("noremap_rdata", HRDATAM, S0);

    // Overlapping regions: slave 0 beats slave 3
    drive(1'b1, 2'b10, 32'h1000_0000);
    #1 check("overlap_hsels", 64'(HSELS), 64'b0001);
    step();
    check("overlap_rdata", HRDATAM, S0);

    drive(1'b0, 2'b00, 32'h0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
